// File: rtl/wb_pkg.sv
// Shared types, load codes and load-data formatting for the writeback stage.
package wb_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 5;
    localparam int unsigned WB_DATA_WIDTH = 64;
    localparam int unsigned WB_CNT_WIDTH  = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_RAW = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        CONFIRM = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic                     reg_write;
        logic                     kill;
        logic                     is_load;
        logic [2:0]               funct3;
        logic [2:0]               addr_lo;
        logic [WB_DATA_WIDTH-1:0] result;
        logic [WB_DATA_WIDTH-1:0] load_data;
    } wb_entry_t;

    // Align the addressed bytes to bit 0, then extend by size/sign; alignment is not checked.
    function automatic logic [WB_DATA_WIDTH-1:0] format_load(
        input logic [2:0]               funct3,
        input logic [2:0]               addr_lo,
        input logic [WB_DATA_WIDTH-1:0] raw
    );
        logic [WB_DATA_WIDTH-1:0] shifted;
        shifted = raw >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   format_load = {{(WB_DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   format_load = {{(WB_DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   format_load = {{(WB_DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   format_load = shifted;
            F3_LBU:  format_load = {{(WB_DATA_WIDTH-8){1'b0}},  shifted[7:0]};
            F3_LHU:  format_load = {{(WB_DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            F3_LWU:  format_load = {{(WB_DATA_WIDTH-32){1'b0}}, shifted[31:0]};
            default: format_load = shifted;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO with 1-bit wrapping pointers and registered full/empty flags.
module wb_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flags only change when occupancy changes; simultaneous push+pop keeps them.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                empty <= 1'b0;
                full  <= (~wr_ptr == rd_ptr);
            end else if (do_pop && !do_push) begin
                full  <= 1'b0;
                empty <= (~rd_ptr == wr_ptr);
            end
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: buffers completed instructions, formats load data,
// drives the register file write port and counts retired instructions.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_WIDTH-1:0]   mem_rd,
    input  logic                    mem_reg_write,
    input  logic                    mem_kill,
    input  logic                    mem_is_load,
    input  logic [2:0]              mem_funct3,
    input  logic [2:0]              mem_addr_lo,
    input  logic [DATA_WIDTH-1:0]   mem_result,
    input  logic [DATA_WIDTH-1:0]   mem_load_data,
    output logic                    write_enable,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [ADDR_WIDTH-1:0]   reset_write_addr,
    input  logic                    write_complete,
    output logic [WB_CNT_WIDTH-1:0] retired_count,
    output logic                    wb_busy
);

    localparam int unsigned ENTRY_WIDTH = $bits(wb_entry_t);

    wb_entry_t              push_entry;
    wb_entry_t              head;
    logic [ENTRY_WIDTH-1:0] head_bits;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_empty_d;

    wb_state_e              state_q;
    wb_state_e              state_d;
    logic [ADDR_WIDTH-1:0]  cur_rd_q;
    logic [ADDR_WIDTH-1:0]  cur_rd_d;
    logic                   cur_kill_q;
    logic                   cur_kill_d;
    logic                   cur_write_q;
    logic                   cur_write_d;
    logic                   load_next;

    logic                    write_enable_d;
    logic [ADDR_WIDTH-1:0]   write_addr_d;
    logic [DATA_WIDTH-1:0]   write_data_d;
    logic [ADDR_WIDTH-1:0]   reset_write_addr_d;
    logic [WB_CNT_WIDTH-1:0] retired_count_d;
    logic                    wb_busy_d;

    assign mem_ready = !fifo_full;
    assign push      = mem_valid && mem_ready;

    always_comb begin
        push_entry           = '0;
        push_entry.rd        = WB_ADDR_WIDTH'(mem_rd);
        push_entry.reg_write = mem_reg_write;
        push_entry.kill      = mem_kill;
        push_entry.is_load   = mem_is_load;
        push_entry.funct3    = mem_funct3;
        push_entry.addr_lo   = mem_addr_lo;
        push_entry.result    = WB_DATA_WIDTH'(mem_result);
        push_entry.load_data = WB_DATA_WIDTH'(mem_load_data);
    end

    wb_fifo #(
        .WIDTH(ENTRY_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head = wb_entry_t'(head_bits);

    // Next state plus next output values; outputs are set up on the edge that enters WRITE.
    always_comb begin
        state_d            = state_q;
        cur_rd_d           = cur_rd_q;
        cur_kill_d         = cur_kill_q;
        cur_write_d        = cur_write_q;
        pop                = 1'b0;
        load_next          = 1'b0;
        write_enable_d     = 1'b0;
        write_addr_d       = '0;
        write_data_d       = '0;
        reset_write_addr_d = '0;
        retired_count_d    = retired_count;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_next = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (cur_kill_q) begin
                    state_d = IDLE;
                end else if (cur_write_q) begin
                    state_d = CONFIRM;
                end else begin
                    retired_count_d = retired_count + WB_CNT_WIDTH'(1);
                end
            end
            CONFIRM: begin
                if (write_complete) begin
                    retired_count_d = retired_count + WB_CNT_WIDTH'(1);
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        load_next = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_next) begin
            cur_rd_d    = ADDR_WIDTH'(head.rd);
            cur_kill_d  = head.kill;
            cur_write_d = !head.kill && head.reg_write && (head.rd != '0);
            if (head.kill) begin
                reset_write_addr_d = ADDR_WIDTH'(head.rd);
            end else if (head.reg_write && (head.rd != '0)) begin
                write_enable_d = 1'b1;
                write_addr_d   = ADDR_WIDTH'(head.rd);
                write_data_d   = head.is_load
                               ? DATA_WIDTH'(format_load(head.funct3, head.addr_lo, head.load_data))
                               : DATA_WIDTH'(head.result);
            end
        end

        // Predict FIFO occupancy after this edge so wb_busy can be registered.
        if (fifo_empty) begin
            fifo_empty_d = !push;
        end else begin
            fifo_empty_d = pop && !push && !fifo_full;
        end
        wb_busy_d = !fifo_empty_d || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cur_rd_q         <= '0;
            cur_kill_q       <= 1'b0;
            cur_write_q      <= 1'b0;
            write_enable     <= 1'b0;
            write_addr       <= '0;
            write_data       <= '0;
            reset_write_addr <= '0;
            retired_count    <= '0;
            wb_busy          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cur_rd_q         <= cur_rd_d;
            cur_kill_q       <= cur_kill_d;
            cur_write_q      <= cur_write_d;
            write_enable     <= write_enable_d;
            write_addr       <= write_addr_d;
            write_data       <= write_data_d;
            reset_write_addr <= reset_write_addr_d;
            retired_count    <= retired_count_d;
            wb_busy          <= wb_busy_d;
        end
    end

    logic unused_cur_rd;
    assign unused_cur_rd = ^cur_rd_q;

endmodule
